// File: rtl/uart_rx_8x.sv
// uart_rx_8x -- byte-wide UART receiver running off an 8x oversampling tick.
//
// The serial line is brought into the clock domain through a 2-FF
// synchronizer. Each bit is decided by majority vote over oversamples 3, 4
// and 5 of its eight ticks. A completed frame is presented as a one-cycle
// valid strobe together with the received data and error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : an even-parity bit follows the data bits; parity_err_out exists
//   undefined : frame = start + DATA_BITS data + stop; no parity_err_out port
//
// Parameters
//   DATA_BITS        data bits per frame, LSB first (5..8)
// Ports
//   clk_in           system clock
//   rst_in           synchronous, active-high reset
//   baud_tick_in     oversample strobe (8 per bit period)
//   rx_in            asynchronous serial line, idles high
//   data_out         last received data word, held until the next frame
//   valid_out        one-cycle pulse when data_out updates
//   framing_err_out  one-cycle pulse with valid_out when the stop bit votes 0
//   busy_out         high while a frame is in progress
//   parity_err_out   (parity build only) pulse with valid_out on parity mismatch

module uart_rx_8x #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 baud_tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 framing_err_out,
    output logic                 busy_out
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Majority of three oversamples.
    function automatic logic maj3(input logic [2:0] v);
        maj3 = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity: data XOR parity bit must be 0, otherwise it is an error.
    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d,
                                             input logic p);
        even_parity_err = (^d) ^ p;
    endfunction
`endif

    logic                 rx_meta_q;
    logic                 rx_s_q;
    state_t               state_q,   state_d;
    logic [2:0]           smp_q,     smp_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           samp_q,    samp_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 busy_q,    busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 pbit_q,    pbit_d;
    logic                 perr_q,    perr_d;
`endif

    logic vote_mid_s;
    logic vote_stop_s;

    // Captures from samples 3..5 of the current bit.
    assign vote_mid_s  = maj3(samp_q);
    // The stop bit is decided on sample 5 itself, so the live line value
    // stands in for the not-yet-registered third capture.
    assign vote_stop_s = maj3({rx_s_q, samp_q[1:0]});

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            smp_q     <= 3'd0;
            bit_cnt_q <= 3'd0;
            samp_q    <= 3'b111;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q    <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            pbit_q    <= pbit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Next-state, counter and output decode; everything holds between ticks.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbit_d    = pbit_q;
        perr_d    = 1'b0;
`endif

        if (baud_tick_in) begin
            smp_d = smp_q + 3'd1;

            case (smp_q)
                3'd3:    samp_d[0] = rx_s_q;
                3'd4:    samp_d[1] = rx_s_q;
                3'd5:    samp_d[2] = rx_s_q;
                default: samp_d    = samp_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    // The detecting tick is sample 0 of the start bit.
                    if (!rx_s_q) begin
                        state_d = S_START;
                        smp_d   = 3'd1;
                    end else begin
                        smp_d   = 3'd0;
                    end
                end
                S_START: begin
                    if (smp_q == 3'd7) begin
                        if (vote_mid_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (smp_q == 3'd7) begin
                        // LSB first: each new bit enters at the top.
                        shift_d   = {vote_mid_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (smp_q == 3'd7) begin
                        pbit_d  = vote_mid_s;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at sample 5 gives half a bit of slack for
                    // rate mismatch before a back-to-back start edge.
                    if (smp_q == 3'd5) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~vote_stop_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = even_parity_err(shift_q, pbit_q);
`endif
                        state_d = S_IDLE;
                        smp_d   = 3'd0;
                    end else begin
                        state_d = S_STOP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    smp_d   = 3'd0;
                end
            endcase
        end else begin
            smp_d = smp_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign data_out        = data_q;
    assign valid_out       = valid_q;
    assign framing_err_out = ferr_q;
    assign busy_out        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_out  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_8x.sv
// Testbench for uart_rx_8x. The tick rate is scaled up tenfold from the
// 115200-baud generator (same 8x oversampling ratio) so that a few dozen
// frames fit in a short run. Expected frames are queued by the line driver
// and matched against each valid_out pulse by a monitor.
`timescale 1ns/1ps

module tb_uart_rx_8x;

    localparam int  DB     = 8;
    localparam real BIT_NS = 868.0556;   // 8 ticks of the scaled tick generator

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          framing_err_out;
    logic          busy_out;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_out;
`endif

    uart_rx_8x #(.DATA_BITS(DB)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .baud_tick_in    (tick),
        .rx_in           (rx),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .framing_err_out (framing_err_out),
        .busy_out        (busy_out)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_out  (parity_err_out)
`endif
    );

    always #5 clk = ~clk;

    // Fractional tick generator: 92160/1e6 ticks per clock (~10.85 clocks/tick).
    int unsigned acc = 0;
    always @(posedge clk) begin
        if (acc + 32'd92160 >= 32'd1000000) begin
            acc  <= acc + 32'd92160 - 32'd1000000;
            tick <= 1'b1;
        end else begin
            acc  <= acc + 32'd92160;
            tick <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frames: {parity_err, framing_err, data}.
    logic [DB+1:0] exp_q[$];
    int            exp_total = 0;
    int            valid_cnt = 0;
    logic          prev_valid = 1'b0;

    // Monitor: match every pulse against the oldest expected frame.
    always @(negedge clk) begin
        logic [DB+1:0] e;
        if (valid_out) begin
            valid_cnt <= valid_cnt + 1;
            check_eq("valid_width", 32'(prev_valid), 32'd0);
            check_eq("busy_at_valid", 32'(busy_out), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(valid_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", 32'(data_out), 32'(e[DB-1:0]));
                check_eq("framing_err", 32'(framing_err_out), 32'(e[DB]));
`ifdef UART_RX_PARITY_EN
                check_eq("parity_err", 32'(parity_err_out), 32'(e[DB+1]));
`endif
            end
        end else if (framing_err_out) begin
            check_eq("ferr_without_valid", 32'(framing_err_out), 32'd0);
        end
        prev_valid <= valid_out;
    end

    // Drive one frame on the line and queue what the receiver must report.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_flip, input real bit_ns);
        logic [DB-1:0] dd;
        logic          pbit;
        dd   = d[DB-1:0];
        pbit = (^dd) ^ par_flip;
        exp_q.push_back({par_flip, ~stop_v, dd});
        exp_total++;
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < DB; i++) begin
            rx = dd[i];
            #(bit_ns);
        end
`ifdef UART_RX_PARITY_EN
        rx = pbit;
        #(bit_ns);
`else
        if (pbit) begin
            rx = 1'b1;
        end
`endif
        rx = stop_v;
        #(bit_ns);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input real n);
        rx = 1'b1;
        #(n * BIT_NS);
    endtask

    initial begin
        int            cnt0;
        logic [7:0]    d;
        logic          stop_v;
        logic          pflip;
        int            ppm;
        real           bns;
        logic [7:0]    b81;

        // Reset values
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_ferr", 32'(framing_err_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
`ifdef UART_RX_PARITY_EN
        check_eq("rst_perr", 32'(parity_err_out), 32'd0);
`endif
        rst = 1'b0;
        idle_bits(2.0);

        // Single byte
        send_frame(8'hA5, 1'b1, 1'b0, BIT_NS);
        idle_bits(1.0);
        check_eq("a5_count", 32'(valid_cnt), 32'd1);
        check_eq("a5_hold", 32'(data_out), 32'hA5);

        // Glitch rejection
        cnt0 = valid_cnt;
        rx = 1'b0;
        #(BIT_NS / 4.0);
        rx = 1'b1;
        #(BIT_NS);
        check_eq("glitch_busy", 32'(busy_out), 32'd0);
        check_eq("glitch_count", 32'(valid_cnt), 32'(cnt0));
        idle_bits(1.0);

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b0, BIT_NS);
        idle_bits(2.0);
        check_eq("ferr_hold", 32'(data_out), 32'h3C);

        // Back-to-back at +3% baud
        cnt0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b0, BIT_NS / 1.03);
        send_frame(8'hFF, 1'b1, 1'b0, BIT_NS / 1.03);
        send_frame(8'h55, 1'b1, 1'b0, BIT_NS / 1.03);
        idle_bits(2.0);
        check_eq("b2b_count", 32'(valid_cnt), 32'(cnt0 + 3));
        check_eq("b2b_hold", 32'(data_out), 32'h55);

        // Reset during data bit 4 of 0x81; the transmitter abandons the frame
        b81 = 8'h81;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b81[i];
            #(BIT_NS);
        end
        rx = b81[4];
        #(BIT_NS / 2.0);
        check_eq("mid_busy", 32'(busy_out), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy_out), 32'd0);
        check_eq("mid_rst_data", 32'(data_out), 32'd0);
        check_eq("mid_rst_valid", 32'(valid_out), 32'd0);
        idle_bits(3.0);
        cnt0 = valid_cnt;
        send_frame(8'h7E, 1'b1, 1'b0, BIT_NS);
        idle_bits(1.0);
        check_eq("after_rst_count", 32'(valid_cnt), 32'(cnt0 + 1));
        check_eq("after_rst_hold", 32'(data_out), 32'h7E);

`ifdef UART_RX_PARITY_EN
        // Parity good then bad
        send_frame(8'h03, 1'b1, 1'b0, BIT_NS);
        send_frame(8'h03, 1'b1, 1'b1, BIT_NS);
        idle_bits(1.0);
`endif

        // Random frames with random baud mismatch within +/-3%
        for (int n = 0; n < 24; n++) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 5) != 0);
            pflip  = ($urandom_range(0, 3) == 0);
            if (stop_v) begin
                ppm = int'($urandom_range(0, 600)) - 300;
            end else begin
                // A low stop bit is followed by a re-started frame that must
                // be rejected; keep the line no slower than nominal here.
                ppm = int'($urandom_range(0, 300));
            end
            bns = BIT_NS / (1.0 + real'(ppm) / 10000.0);
            send_frame(d, stop_v, pflip, bns);
            if (!stop_v) begin
                idle_bits(2.0);
            end else if ($urandom_range(0, 1) == 1) begin
                idle_bits(real'($urandom_range(1, 4)) / 2.0);
            end else begin
                rx = 1'b1;
            end
        end
        idle_bits(1.0);

        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check_eq("pending_frames", 32'(exp_q.size()), 32'd0);
        check_eq("valid_total", 32'(valid_cnt), 32'(exp_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
